// File: rtl/video_timing_pkg.sv
// Shared timing defaults, counter sizing and the sequencer state encoding
// for the video timing generator.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 48;
    localparam int H_BP_DEF     = 40;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 13;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 29;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/video_timing_counter.sv
// Wrapping up-counter 0..MAX-1 with synchronous clear; wrap flags the
// cycle in which an increment rolls the count back to zero.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int MAX = 1024
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX - 1);

    logic last;

    assign last = (cnt == LAST_VAL);
    assign wrap = inc & last;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters, sync/de/position decode registered
// one pclk behind the counters, and a run/stop sequencer that only halts on
// a frame boundary.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | counters held at 0, outputs idle; en=1 starts a frame
//   ST_RUN  | counting, en high
//   ST_STOP | counting, en low; halts at the last cycle of the frame
module video_timing
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
        $error("video_timing: H_TOTAL exceeds 10-bit counter range");
    end
    if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
        $error("video_timing: V_TOTAL exceeds 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_ACT_L = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_L = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    state_t           state, state_nxt;
    logic             counting;
    logic             h_wrap, frame_end;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             act_d, hs_d, vs_d, fs_d;

    assign counting = (state != ST_IDLE);

    video_timing_counter #(.MAX(H_TOTAL)) u_hcnt (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (!counting),
        .inc   (counting),
        .cnt   (hcnt),
        .wrap  (h_wrap)
    );

    // v wrap only fires together with an h wrap, so it marks the frame end.
    video_timing_counter #(.MAX(V_TOTAL)) u_vcnt (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (!counting),
        .inc   (h_wrap),
        .cnt   (vcnt),
        .wrap  (frame_end)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = frame_end ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (frame_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        act_d = counting && (hcnt < H_ACT_L) && (vcnt < V_ACT_L);
        hs_d  = counting && (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_d  = counting && (vcnt >= VS_BEG) && (vcnt < VS_END);
        fs_d  = counting && (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ~hs_d;
            vsync       <= ~vs_d;
            de          <= act_d;
            x           <= act_d ? hcnt : '0;
            y           <= act_d ? vcnt : '0;
            frame_start <= fs_d;
        end
    end

endmodule
